// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
//
// Purpose:
//    Bundles the two handshakes of the instruction prefetch queue: the
//    request/grant/response instruction-memory bus and the valid/ready
//    stream toward the core's fetch stage.
//
// Signals:
//    bus_req     fetch request valid                  (queue -> memory)
//    bus_addr    word-aligned fetch address           (queue -> memory)
//    bus_gnt     request accepted this cycle          (memory -> queue)
//    bus_rvalid  in-order response data valid         (memory -> queue)
//    bus_rdata   response instruction                 (memory -> queue)
//    out_valid   buffered instruction available       (queue -> fetch)
//    out_pc      PC of the head instruction           (queue -> fetch)
//    out_instr   head instruction                     (queue -> fetch)
//    out_ready   fetch stage consumes the head        (fetch -> queue)
//
// Modports:
//    master  the prefetch queue itself
//    slave   the environment (memory bus plus fetch stage)
// ----------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int Width = 32
);

   logic             bus_req;
   logic [Width-1:0] bus_addr;
   logic             bus_gnt;
   logic             bus_rvalid;
   logic [Width-1:0] bus_rdata;

   logic             out_valid;
   logic [Width-1:0] out_pc;
   logic [Width-1:0] out_instr;
   logic             out_ready;

   modport master (
      output bus_req,
      output bus_addr,
      input  bus_gnt,
      input  bus_rvalid,
      input  bus_rdata,
      output out_valid,
      output out_pc,
      output out_instr,
      input  out_ready
   );

   modport slave (
      input  bus_req,
      input  bus_addr,
      output bus_gnt,
      output bus_rvalid,
      output bus_rdata,
      input  out_valid,
      input  out_pc,
      input  out_instr,
      output out_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//    Instruction prefetch queue. Generates sequential fetch addresses, issues
//    them on a request/grant bus whose responses come back in order with a
//    variable latency, buffers each response together with its PC, and
//    hands them to the fetch stage over a valid/ready handshake. A redirect
//    (flush) empties the queue and restarts fetching at flush_pc; responses
//    still owed by the bus for the old stream are counted and dropped.
//
// Parameters:
//    Depth    in-flight plus buffered fetch entries (power of two, >= 2)
//    Width    address / instruction width
//    ResetPc  first fetch address after reset
//
// Ports:
//    clk       clock, rising edge
//    rst       asynchronous active-high reset
//    flush     redirect: discard all queued and in-flight fetches
//    flush_pc  restart address, sampled while flush=1
//    err       sticky: a response arrived with nothing outstanding
//    fq        fetch_queue_if.master (memory bus + fetch-stage stream)
// ----------------------------------------------------------------------------
module fetch_queue #(
   parameter int               Depth   = 4,
   parameter int               Width   = 32,
   parameter logic [Width-1:0] ResetPc = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [Width-1:0] flush_pc,
   output logic             err,
   fetch_queue_if.master    fq
);

   localparam int IdxW = $clog2(Depth);
   localparam int PtrW = IdxW + 1;

   // Pointers carry one extra wrap bit so that full and empty differ.
   logic [Width-1:0] fetch_pc;
   logic [PtrW-1:0]  alloc_ptr;
   logic [PtrW-1:0]  fill_ptr;
   logic [PtrW-1:0]  pop_ptr;
   logic [PtrW-1:0]  drop_cnt;

   logic [Width-1:0] pc_mem    [Depth];
   logic [Width-1:0] instr_mem [Depth];

   logic [PtrW-1:0]  outstanding;
   logic [PtrW-1:0]  filled;
   logic [PtrW-1:0]  used;
   logic [PtrW:0]    credit_sum;
   logic             credit;
   logic             grant;
   logic             consume;
   logic             has_drop;
   logic             has_outstanding;
   logic             drop_rsp;
   logic             fill_rsp;
   logic             stray_rsp;
   logic             retire_rsp;
   logic [PtrW-1:0]  flush_drop;

   // Occupancy figures derived from the pointer differences.
   assign outstanding = alloc_ptr - fill_ptr;
   assign filled      = fill_ptr - pop_ptr;
   assign used        = alloc_ptr - pop_ptr;

   // Old-stream responses still owed by the bus occupy credit just like
   // live entries, so a redirect cannot overrun the bus's response queue.
   assign credit_sum = {1'b0, used} + {1'b0, drop_cnt};
   assign credit     = credit_sum < (PtrW+1)'(Depth);

   assign fq.bus_req  = ~rst & ~flush & credit;
   assign fq.bus_addr = fetch_pc;
   assign grant       = fq.bus_req & fq.bus_gnt;

   // A response first pays off any pending drops; only then does it fill
   // the oldest outstanding entry. With neither it is a protocol error.
   assign has_drop        = drop_cnt != '0;
   assign has_outstanding = outstanding != '0;
   assign drop_rsp        = fq.bus_rvalid & has_drop;
   assign fill_rsp        = fq.bus_rvalid & ~has_drop & has_outstanding;
   assign stray_rsp       = fq.bus_rvalid & ~has_drop & ~has_outstanding;
   assign retire_rsp      = drop_rsp | fill_rsp;

   // On redirect every outstanding fetch becomes a response to throw away,
   // less the one that is being retired in the flush cycle itself.
   assign flush_drop = drop_cnt + outstanding - PtrW'(retire_rsp);

   assign fq.out_valid = (filled != '0) & ~flush;
   assign fq.out_pc    = pc_mem[pop_ptr[IdxW-1:0]];
   assign fq.out_instr = instr_mem[pop_ptr[IdxW-1:0]];
   assign consume      = fq.out_valid & fq.out_ready;

   // Fetch address and pointer state. Flush wins over every other update
   // in its cycle and collapses the queue to empty at the allocation point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc  <= ResetPc;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         pop_ptr   <= '0;
         drop_cnt  <= '0;
      end else if (flush) begin
         fetch_pc <= flush_pc;
         fill_ptr <= alloc_ptr;
         pop_ptr  <= alloc_ptr;
         drop_cnt <= flush_drop;
      end else begin
         if (grant) begin
            alloc_ptr <= alloc_ptr + 1'b1;
            fetch_pc  <= fetch_pc + Width'(4);
         end
         if (fill_rsp) begin
            fill_ptr <= fill_ptr + 1'b1;
         end
         if (drop_rsp) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
         if (consume) begin
            pop_ptr <= pop_ptr + 1'b1;
         end
      end
   end

   // Sticky error: a response with no fetch to match it, including one
   // that shows up in a flush cycle. Only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (stray_rsp) begin
         err <= 1'b1;
      end
   end

   // Entry storage. The PC is written at grant time and the instruction
   // when its response arrives; contents of empty slots are never shown
   // because out_valid masks them, so the arrays need no reset.
   always_ff @(posedge clk) begin
      if (grant) begin
         pc_mem[alloc_ptr[IdxW-1:0]] <= fetch_pc;
      end
      if (fill_rsp & ~flush & ~rst) begin
         instr_mem[fill_ptr[IdxW-1:0]] <= fq.bus_rdata;
      end
   end

endmodule
